// File: rtl/stage_ifetch.sv
// stage_ifetch: instruction fetch feeding the decode stage.
// Prefetches opcode bytes into a small FIFO; handles redirect and halt.
module stage_ifetch #(
  parameter int PC_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_re,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic [7:0]          mem_data,
  input  logic                mem_drdy,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [7:0]          opcode,
  output logic                drdy,
  input  logic                ack_in,
  output logic                halted
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                re_q, re_d;
  logic                discard_q, discard_d;
  logic [7:0]          fifo_q [FIFO_DEPTH];
  logic [AW-1:0]       rd_q, rd_d;
  logic [AW-1:0]       wr_q, wr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          op_q, op_d;
  logic                drdy_q, drdy_d;
  logic                push, pop;

  // next-state: fetch FSM, FIFO pointers and registered head byte
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    re_d      = 1'b0;
    discard_d = discard_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (redirect) begin
      pc_d  = redirect_pc;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      if (state_q == S_WAIT && !mem_drdy) begin
        state_d   = S_WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cnt_q < CW'(FIFO_DEPTH)) begin
            re_d    = 1'b1;
            addr_d  = pc_q;
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_drdy) begin
            state_d = S_IDLE;
            if (discard_q) begin
              discard_d = 1'b0;
            end else if (mem_data == 8'h00) begin
              state_d = S_HALT;
            end else begin
              push = 1'b1;
            end
          end
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
      pop = drdy_q && ack_in;
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    drdy_d = (cnt_d != '0);
    if (cnt_d == '0) begin
      op_d = 8'h00;
    end else if (push && wr_q == rd_d) begin
      op_d = mem_data;
    end else begin
      op_d = fifo_q[rd_d];
    end
  end

  // control and pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      addr_q    <= '0;
      re_q      <= 1'b0;
      discard_q <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      op_q      <= 8'h00;
      drdy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      re_q      <= re_d;
      discard_q <= discard_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      drdy_q    <= drdy_d;
    end
  end

  // prefetch storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 8'h00;
      end
    end else if (push) begin
      fifo_q[wr_q] <= mem_data;
    end
  end

  assign mem_re   = re_q;
  assign mem_addr = addr_q;
  assign opcode   = op_q;
  assign drdy     = drdy_q;
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_stage_ifetch.sv
// tb_stage_ifetch: randomized + directed bench for stage_ifetch.
// Reference: the opcode stream is prog[P], prog[P+1], ... up to a zero.
module tb_stage_ifetch;

  localparam int PW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_re;
  logic [PW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'h00;
  logic          mem_drdy = 1'b0;
  logic          redirect = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic [7:0]    opcode;
  logic          drdy;
  logic          ack_in = 1'b0;
  logic          halted;

  stage_ifetch #(
    .PC_WIDTH  (PW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_drdy   (mem_drdy),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .opcode     (opcode),
    .drdy       (drdy),
    .ack_in     (ack_in),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]    prog [65536];
  logic [7:0]    exp_q [$];
  logic [PW-1:0] exp_addr = '0;
  logic [PW-1:0] zero_addr = '0;
  bit            zero_seen = 1'b0;
  int            nre = 0;
  logic [PW-1:0] re_log [$];
  bit            prev_re = 1'b0;
  int            ncyc = 0;
  int            lat = 1;
  bit            lat_rand = 1'b0;

  typedef struct {
    logic [PW-1:0] a;
    int            due;
  } req_t;
  req_t mq [$];

  task automatic check(input string nm, input longint act,
                       input longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // expected stream after a (re)start at p
  task automatic reload(input logic [PW-1:0] p);
    logic [PW-1:0] a;
    a = p;
    exp_q.delete();
    re_log.delete();
    zero_seen = 1'b0;
    nre = 0;
    exp_addr = p;
    for (int i = 0; i < 65536; i++) begin
      if (prog[a] == 8'h00) break;
      exp_q.push_back(prog[a]);
      a = a + 1'b1;
    end
    zero_addr = a;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect = 1'b0;
    reload('0);
    step(1);
    check("rst_drdy", drdy, 0);
    check("rst_re", mem_re, 0);
    check("rst_halted", halted, 0);
    check("rst_opcode", opcode, 0);
    check("rst_addr", mem_addr, 0);
    step(1);
    reset = 1'b1;
  endtask

  task automatic redirect_to(input logic [PW-1:0] p);
    redirect = 1'b1;
    redirect_pc = p;
    reload(p);
    step(1);
    redirect = 1'b0;
  endtask

  task automatic wait_halt(input int limit, input string nm);
    int n;
    n = 0;
    while (!halted && n < limit) begin
      step(1);
      n++;
    end
    check(nm, halted, 1);
  endtask

  // program memory: in-order responses, stale reply on reset
  always @(negedge clk) begin
    int l;
    ncyc++;
    mem_drdy = 1'b0;
    if (!reset) begin
      if (mq.size() > 0) begin
        mem_drdy = 1'b1;
        mem_data = prog[mq[0].a];
      end
      mq.delete();
    end else begin
      if (mem_re) check("one_outstanding", mq.size(), 0);
      if (mq.size() > 0 && mq[0].due <= ncyc) begin
        mem_drdy = 1'b1;
        mem_data = prog[mq[0].a];
        void'(mq.pop_front());
      end
      if (mem_re) begin
        l = lat_rand ? int'($urandom_range(1, 3)) : lat;
        mq.push_back('{a: mem_addr, due: ncyc + l});
      end
    end
  end

  // monitor: fetch side at negedge, consume side once inputs settle
  always @(negedge clk) begin
    logic [7:0] eb;
    if (reset) begin
      if (mem_re) begin
        check("re_pulse", prev_re, 0);
        check("fetch_after_halt", zero_seen, 0);
        check("mem_addr", mem_addr, exp_addr);
        re_log.push_back(mem_addr);
        nre++;
        if (exp_addr == zero_addr) zero_seen = 1'b1;
        exp_addr = exp_addr + 1'b1;
      end
      if (!drdy) check("opcode_idle", opcode, 0);
      if (halted) check("halt_cause", zero_seen, 1);
    end
    prev_re = mem_re;
    #2;
    if (reset && drdy && ack_in && !redirect) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL opcode_extra: got %02h expected none", opcode);
      end else begin
        eb = exp_q.pop_front();
        if (opcode !== eb) begin
          miscompares++;
          $display("FAIL opcode: got %02h expected %02h", opcode, eb);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    for (int i = 0; i < 65536; i++) prog[i] = 8'h11;

    // 1: "+>+" then halt, latency 1
    prog[0] = 8'h2B; prog[1] = 8'h3E;
    prog[2] = 8'h2B; prog[3] = 8'h00;
    lat = 1; lat_rand = 1'b0; ack_in = 1'b1;
    do_reset();
    step(1);
    check("first_re", mem_re, 1);
    check("first_addr", mem_addr, 0);
    step(1);
    check("lat_drdy_lo", drdy, 0);
    step(1);
    check("lat_drdy_hi", drdy, 1);
    check("lat_opcode", opcode, 8'h2B);
    wait_halt(60, "t1_halt");
    step(4);
    check("t1_reads", nre, 4);
    check("t1_drained", exp_q.size(), 0);

    // 2: fill with ack held low, then drain back-to-back
    for (int i = 0; i < 16; i++) prog[i] = (i % 2) ? 8'h3E : 8'h2B;
    prog[16] = 8'h00;
    ack_in = 1'b0;
    do_reset();
    step(30);
    check("t2_fill_reads", nre, DEPTH);
    check("t2_drdy", drdy, 1);
    check("t2_hold_op", opcode, 8'h2B);
    ack_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain_drdy", drdy, 1);
      step(1);
    end
    wait_halt(200, "t2_halt");
    step(4);
    check("t2_reads", nre, 17);
    check("t2_drained", exp_q.size(), 0);

    // 3: redirect with a read outstanding, latency 3
    for (int i = 0; i < 12; i++) prog[i] = 8'(8'h10 + i);
    prog[12] = 8'h00;
    for (int i = 0; i < 8; i++) prog[16 + i] = 8'(8'h50 + i);
    prog[24] = 8'h00;
    lat = 3; ack_in = 1'b1;
    do_reset();
    n = 0;
    while (!(mem_re && mem_addr == 16'h0005) && n < 200) begin
      step(1);
      n++;
    end
    check("t3_found_5", mem_addr, 16'h0005);
    redirect_to(16'h0010);
    check("t3_flush_drdy", drdy, 0);
    wait_halt(200, "t3_halt");
    step(4);
    check("t3_first_addr", re_log.size() > 0 ? re_log[0] : 16'hDEAD,
          16'h0010);
    check("t3_reads", nre, 9);
    check("t3_drained", exp_q.size(), 0);

    // 4: redirect out of halt
    redirect_to(16'h0000);
    check("t4_halt_clear", halted, 0);
    wait_halt(200, "t4_halt");
    step(4);
    check("t4_first_addr", re_log.size() > 0 ? re_log[0] : 16'hDEAD, 0);
    check("t4_reads", nre, 13);
    check("t4_drained", exp_q.size(), 0);

    // 5: pc wraps from 0xFFFF to 0x0000
    prog[16'hFFFF] = 8'h41;
    redirect_to(16'hFFFF);
    wait_halt(300, "t5_halt");
    step(4);
    check("t5_addr0", re_log.size() > 1 ? re_log[0] : 16'hDEAD, 16'hFFFF);
    check("t5_addr1", re_log.size() > 1 ? re_log[1] : 16'hDEAD, 16'h0000);
    check("t5_drained", exp_q.size(), 0);

    // 6: reset while a read is outstanding and FIFO holds 3
    ack_in = 1'b0; lat = 3;
    do_reset();
    n = 0;
    while (nre < DEPTH && n < 200) begin
      step(1);
      n++;
    end
    check("t6_reads", nre, DEPTH);
    check("t6_pre_drdy", drdy, 1);
    check("t6_pre_re", mem_re, 1);
    reset = 1'b0;
    reload('0);
    #1;
    check("t6_async_drdy", drdy, 0);
    check("t6_async_re", mem_re, 0);
    check("t6_async_halted", halted, 0);
    check("t6_async_op", opcode, 0);
    step(1);
    reset = 1'b1;
    step(1);
    check("t6_stale_drdy", drdy, 0);
    check("t6_restart_re", mem_re, 1);
    check("t6_restart_addr", mem_addr, 0);
    ack_in = 1'b1;
    wait_halt(300, "t6_halt");
    step(4);
    check("t6_drained", exp_q.size(), 0);

    // random: program, latency, acks, redirects, resets
    for (int i = 0; i < 65536; i++) begin
      prog[i] = ($urandom_range(0, 31) == 0) ? 8'h00 :
                8'($urandom_range(1, 255));
    end
    prog[16'h8000] = 8'h00;
    lat_rand = 1'b1;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      ack_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 39) == 0 ||
                   (halted && $urandom_range(0, 7) == 0)) begin
        redirect_to(PW'($urandom_range(0, 65535)));
      end else begin
        step(1);
      end
    end
    ack_in = 1'b1;
    wait_halt(5000, "rand_halt");
    step(4);
    check("rand_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
